// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and default parameters for the score point collector
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } score_col_state_t;

    localparam int SCORE_DATA_W      = 8;
    localparam int SCORE_NUM_PTS     = 5;
    localparam int SCORE_NUM_CH      = 2;
    localparam int SCORE_START_DELAY = 2;

endpackage

// File: rtl/score_start_delay.sv
// rtl/score_start_delay.sv - loadable down-counter timing the settle delay after start
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   i_clear    synchronous zeroing of the counter (frame abort)
//   i_load     load START_DELAY-1 (start accepted)
//   i_dec      decrement by one, saturating at zero
//   o_done     counter is zero
module score_start_delay #(
    parameter int START_DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);

    localparam int CNT_W = $clog2(START_DELAY + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(START_DELAY - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/score_point_collector.sv
// rtl/score_point_collector.sv - gathers NUM_PTS samples per channel and publishes them as one frame
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   start       frame-start request; ignored (and flags overrun) while busy
//   clear       synchronous abort; returns to IDLE and clears overrun
//   in_valid    qualifies in_data during collection
//   in_data     channel c at [c*DATA_W +: DATA_W]
//   out_data    channel c, point k at [(c*NUM_PTS+k)*DATA_W +: DATA_W]
//   out_valid   one-cycle strobe marking a newly published frame
//   busy        state is not IDLE
//   overrun     sticky flag: start arrived while busy
module score_point_collector
    import score_pkg::*;
#(
    parameter int DATA_W      = SCORE_DATA_W,
    parameter int NUM_PTS     = SCORE_NUM_PTS,
    parameter int NUM_CH      = SCORE_NUM_CH,
    parameter int START_DELAY = SCORE_START_DELAY
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             clear,
    input  logic                             in_valid,
    input  logic [NUM_CH*DATA_W-1:0]         in_data,
    output logic [NUM_CH*NUM_PTS*DATA_W-1:0] out_data,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int BUF_W = NUM_CH * NUM_PTS * DATA_W;
    localparam int IDX_W = $clog2(NUM_PTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS - 1);

    score_col_state_t r_state;
    score_col_state_t w_next_state;

    logic [IDX_W-1:0] r_idx;
    logic [BUF_W-1:0] r_shadow;
    logic [BUF_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_overrun;

    logic w_load;
    logic w_dec;
    logic w_capture;
    logic w_publish;
    logic w_delay_done;
    logic w_busy;

    assign w_busy = (r_state != ST_IDLE);

    score_start_delay #(
        .START_DELAY(START_DELAY)
    ) u_start_delay (
        .clk    (clk),
        .rst    (rst),
        .i_clear(clear),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_done (w_delay_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // clear overrides every transition, including the publish out of DONE
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_capture    = 1'b0;
        w_publish    = 1'b0;
        if (clear) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next_state = ST_DELAY;
                        w_load       = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (w_delay_done) begin
                        w_next_state = ST_COLLECT;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        w_capture = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_next_state = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_publish    = 1'b1;
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Point index wraps after the last capture so the next frame starts at slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (clear) begin
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_capture) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[(c * NUM_PTS + int'(r_idx)) * DATA_W +: DATA_W] <= in_data[c * DATA_W +: DATA_W];
            end
        end
    end

    // Output register is only loaded from a completed shadow, so partial frames never leak out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_publish;
            if (w_publish) begin
                r_out_data <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_overrun <= 1'b0;
        end else if (start && w_busy) begin
            r_overrun <= 1'b1;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = w_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_score_point_collector.sv
// tb/tb_score_point_collector.sv - directed self-checking bench for score_point_collector
module tb_score_point_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start    = 1'b0;
    logic        clear    = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data  = '0;
    logic [79:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    logic         s_start    = 1'b0;
    logic         s_clear    = 1'b0;
    logic         s_in_valid = 1'b0;
    logic [47:0]  s_in_data  = '0;
    logic [143:0] s_out_data;
    logic         s_out_valid;
    logic         s_busy;
    logic         s_overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    score_point_collector dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    score_point_collector #(
        .DATA_W     (12),
        .NUM_PTS    (3),
        .NUM_CH     (4),
        .START_DELAY(1)
    ) dut_sweep (
        .clk      (clk),
        .rst      (rst),
        .start    (s_start),
        .clear    (s_clear),
        .in_valid (s_in_valid),
        .in_data  (s_in_data),
        .out_data (s_out_data),
        .out_valid(s_out_valid),
        .busy     (s_busy),
        .overrun  (s_overrun)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ch0(input int k, input logic [7:0] xr);
        logic [7:0] v;
        v = 8'(8'h11 * (k + 1));
        return v ^ xr;
    endfunction

    function automatic logic [7:0] ch1(input int k, input logic [7:0] xr);
        logic [7:0] v;
        v = 8'(8'hA1 + k);
        return v ^ xr;
    endfunction

    function automatic logic [79:0] frame_exp(input logic [7:0] xr);
        logic [79:0] f;
        f = '0;
        for (int k = 0; k < 5; k++) begin
            f[k*8 +: 8]       = ch0(k, xr);
            f[(5 + k)*8 +: 8] = ch1(k, xr);
        end
        return f;
    endfunction

    // Edge e=0 carries the start. Captures begin at edge 3 and follow in_valid;
    // k tracks how many points the collector has taken so far.
    task automatic run_frame(input int nedges, input logic [31:0] stall, input int ov_e,
                             input int clr_e, input int valid_e, input logic [7:0] xr);
        int k;
        k = 0;
        for (int e = 0; e < nedges; e++) begin
            start    = (e == 0) || (e == ov_e);
            clear    = (e == clr_e);
            in_valid = !stall[e];
            in_data  = (e >= 3 && k < 5) ? {ch1(k, xr), ch0(k, xr)} : 16'hDEAD;
            step();
            if (e >= 3 && !stall[e] && k < 5 && (clr_e < 0 || e < clr_e)) k++;
            check("out_valid", {159'd0, out_valid}, {159'd0, (e == valid_e)});
            check("overrun", {159'd0, overrun},
                  {159'd0, (ov_e >= 0 && e >= ov_e && (clr_e < 0 || e < clr_e))});
            if (e == 1) check("busy_running", {159'd0, busy}, 160'd1);
            if (e == clr_e) check("busy_after_clear", {159'd0, busy}, 160'd0);
        end
        start    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [143:0] s_exp;

        // reset state
        #12;
        check("rst_out_data", {80'd0, out_data}, 160'd0);
        check("rst_out_valid", {159'd0, out_valid}, 160'd0);
        check("rst_busy", {159'd0, busy}, 160'd0);
        check("rst_overrun", {159'd0, overrun}, 160'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // nominal frame; L = 7, out_valid at 8; next start lands at L+2
        run_frame(9, 32'h0, -1, -1, 8, 8'h00);
        check("nominal_data", {80'd0, out_data}, {80'd0, 80'hA5A4A3A2A1_5544332211});

        // back-to-back start with stalls on edges 4 and 6: L = 9, out_valid at 10
        run_frame(12, 32'h50, -1, -1, 10, 8'h00);
        check("stall_data", {80'd0, out_data}, {80'd0, 80'hA5A4A3A2A1_5544332211});
        check("stall_busy_low", {159'd0, busy}, 160'd0);

        // overrun at edge 5, frame completes unaffected, clear at 12
        run_frame(14, 32'h0, 5, 12, 8, 8'h22);
        check("overrun_data", {80'd0, out_data}, {80'd0, frame_exp(8'h22)});

        // abort at edge 5 mid-collection: previous frame retained
        run_frame(10, 32'h0, -1, 5, -1, 8'h33);
        check("abort_retain", {80'd0, out_data}, {80'd0, frame_exp(8'h22)});
        check("abort_idle", {159'd0, busy}, 160'd0);

        // frame after abort starts at point 0 again
        run_frame(9, 32'h0, -1, -1, 8, 8'h44);
        check("post_abort_data", {80'd0, out_data}, {80'd0, frame_exp(8'h44)});

        // clear+start together while busy with overrun set, then from IDLE
        step();
        start = 1'b1;
        step();
        step();
        check("cs_overrun_set", {159'd0, overrun}, 160'd1);
        clear = 1'b1;
        step();
        check("cs_busy_busy", {159'd0, busy}, 160'd0);
        check("cs_overrun_clr", {159'd0, overrun}, 160'd0);
        step();
        check("cs_busy_idle", {159'd0, busy}, 160'd0);
        start = 1'b0;
        clear = 1'b0;
        step();
        check("cs_dropped", {159'd0, busy}, 160'd0);
        check("cs_no_valid", {159'd0, out_valid}, 160'd0);

        // reset mid-frame between edges 4 and 5
        run_frame(5, 32'h0, 2, -1, -1, 8'h55);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_data", {80'd0, out_data}, 160'd0);
        check("arst_out_valid", {159'd0, out_valid}, 160'd0);
        check("arst_busy", {159'd0, busy}, 160'd0);
        check("arst_overrun", {159'd0, overrun}, 160'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("arst_idle", {159'd0, busy}, 160'd0);
        run_frame(9, 32'h0, -1, -1, 8, 8'h66);
        check("arst_fresh_data", {80'd0, out_data}, {80'd0, frame_exp(8'h66)});

        // parameter sweep: 4 ch x 3 pts x 12 bit, START_DELAY=1 -> out_valid at E+5
        s_exp = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) begin
                s_exp[(c*3 + k)*12 +: 12] = 12'(12'h101 + c*16 + k);
            end
        end
        for (int e = 0; e < 8; e++) begin
            s_start    = (e == 0);
            s_in_valid = 1'b1;
            for (int c = 0; c < 4; c++) begin
                s_in_data[c*12 +: 12] = (e >= 2 && e <= 4) ? 12'(12'h101 + c*16 + (e - 2)) : 12'hFFF;
            end
            step();
            check("sweep_out_valid", {159'd0, s_out_valid}, {159'd0, (e == 5)});
        end
        s_start    = 1'b0;
        s_in_valid = 1'b0;
        check("sweep_data", {16'd0, s_out_data}, {16'd0, s_exp});
        check("sweep_busy", {159'd0, s_busy}, 160'd0);
        check("sweep_overrun", {159'd0, s_overrun}, 160'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
